// File: rtl/ring_counter_scanner_pkg.sv
// rtl/ring_counter_scanner_pkg.sv - slot constants and helpers shared by the scanner and mux-side checks
package ring_counter_scanner_pkg;

  localparam logic [3:0] SLOT_0 = 4'b0001;
  localparam logic [3:0] SLOT_1 = 4'b0010;
  localparam logic [3:0] SLOT_2 = 4'b0100;
  localparam logic [3:0] SLOT_3 = 4'b1000;

  function automatic int cnt_width(input int divider);
    return (divider <= 2) ? 1 : $clog2(divider);
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return $onehot(v);
  endfunction

endpackage

// File: rtl/ring_counter_scanner_if.sv
// rtl/ring_counter_scanner_if.sv - enable in, slot select / index / frame strobe out
interface ring_counter_scanner_if;
  logic       enable;
  logic [3:0] ring_counter;
  logic [1:0] index;
  logic       frame_done;

  modport master (output enable, input ring_counter, index, frame_done);
  modport slave  (input enable, output ring_counter, index, frame_done);
endinterface

// File: rtl/ring_counter_scanner_prescaler.sv
// rtl/ring_counter_scanner_prescaler.sv - per-slot cycle counter producing the slot tick and guard flag
module ring_counter_scanner_prescaler
  import ring_counter_scanner_pkg::*;
#(
  parameter int DIVIDER = 4,
  parameter int GUARD   = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick,
  output logic in_guard
);

  localparam int W = cnt_width(DIVIDER);

  logic [W-1:0] cnt_q, cnt_d;
  logic         last_cycle;

  assign last_cycle = (cnt_q == W'(DIVIDER - 1));
  assign tick       = enable && last_cycle;

  always_comb begin
    cnt_d = cnt_q;
    if (enable) cnt_d = last_cycle ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // With no guard the compare would be constant-false, so tie it off explicitly.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (cnt_q < W'(GUARD));
    end
  endgenerate

endmodule

// File: rtl/ring_counter_scanner.sv
// rtl/ring_counter_scanner.sv - one-hot slot rotation with guard blanking, slot index and frame strobe
module ring_counter_scanner
  import ring_counter_scanner_pkg::*;
#(
  parameter int DIVIDER = 4,
  parameter int GUARD   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  ring_counter_scanner_if.slave bus
);

  logic [3:0] pos_q, pos_d;
  logic       tick, in_guard, pos_ok;
  logic [1:0] idx;

  ring_counter_scanner_prescaler #(.DIVIDER(DIVIDER), .GUARD(GUARD)) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .enable   (bus.enable),
    .tick     (tick),
    .in_guard (in_guard)
  );

  assign pos_ok = is_onehot4(pos_q);

  // A corrupted ring is replaced by slot 0 at the next slot boundary rather than rotated.
  always_comb begin
    pos_d = pos_q;
    if (tick) pos_d = pos_ok ? {pos_q[2:0], pos_q[3]} : SLOT_0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)           pos_q <= SLOT_0;
    else if (bus.enable) pos_q <= pos_d;
  end

  always_comb begin
    idx = 2'd0;
    case (pos_q)
      SLOT_0:  idx = 2'd0;
      SLOT_1:  idx = 2'd1;
      SLOT_2:  idx = 2'd2;
      SLOT_3:  idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  assign bus.ring_counter = (bus.enable && pos_ok && !in_guard) ? pos_q : 4'b0000;
  assign bus.index        = idx;
  assign bus.frame_done   = tick && (pos_q == SLOT_3);

  always_ff @(posedge clock) begin
    if (!reset) assert (bus.ring_counter == 4'b0000 || is_onehot4(bus.ring_counter));
  end

endmodule

// File: tb/tb_ring_counter_scanner.sv
// tb/tb_ring_counter_scanner.sv - scoreboard bench for ring_counter_scanner
module tb_ring_counter_scanner;

  localparam int DA = 4;
  localparam int GA = 1;

  typedef struct packed {
    logic [3:0] rc;
    logic [1:0] idx;
    logic       fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;

  ring_counter_scanner_if bus_a ();
  ring_counter_scanner_if bus_b ();

  ring_counter_scanner #(.DIVIDER(DA), .GUARD(GA)) dut_a (
    .clock (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  ring_counter_scanner #(.DIVIDER(2), .GUARD(0)) dut_b (
    .clock (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model for DUT A: slot number, cycle-in-slot, ring-valid flag.
  int m_cnt   = 0;
  int m_slot  = 0;
  bit m_valid = 1'b1;

  // Scenario-1 reference sequence after k edges from reset (k = 0..15).
  logic [3:0] s1_rc [16] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2,
                             4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8};
  logic [3:0] b_rc [8]   = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8};

  int tab_idx   = 16;
  int b_n       = 0;
  int b_samples = 0;
  int b_frames  = 0;
  bit forced    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_exp(input logic en);
    exp_t e;
    e.rc  = (en && m_valid && m_cnt >= GA) ? 4'(1 << m_slot) : 4'b0000;
    e.idx = m_valid ? 2'(m_slot) : 2'd0;
    e.fd  = en && m_valid && m_slot == 3 && m_cnt == DA - 1;
    return e;
  endfunction

  task automatic model_step(input logic en);
    if (en) begin
      if (m_cnt == DA - 1) begin
        m_cnt = 0;
        if (!m_valid) begin
          m_slot  = 0;
          m_valid = 1'b1;
        end else begin
          m_slot = (m_slot + 1) % 4;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic push_b();
    exp_t e;
    e.rc  = b_rc[b_n % 8];
    e.idx = 2'((b_n % 8) / 2);
    e.fd  = (b_n % 8) == 7;
    q_b.push_back(e);
    b_n++;
  endtask

  task automatic push_all(input logic en);
    exp_t e;
    bus_a.enable = en;
    bus_b.enable = 1'b1;
    if (tab_idx < 16) begin
      e.rc  = s1_rc[tab_idx];
      e.idx = 2'(tab_idx / 4);
      e.fd  = (tab_idx == 15);
      tab_idx++;
    end else begin
      e = model_exp(en);
    end
    q_a.push_back(e);
    model_step(en);
    push_b();
  endtask

  task automatic drive(input logic en);
    @(negedge clk);
    if (forced) begin
      release dut_a.pos_q;
      forced = 1'b0;
    end
    push_all(en);
  endtask

  task automatic drive_corrupt();
    @(negedge clk);
    force dut_a.pos_q = 4'b0110;
    forced  = 1'b1;
    m_valid = 1'b0;
    push_all(1'b1);
  endtask

  task automatic pulse_reset_a();
    @(negedge clk);
    bus_a.enable = 1'b0;
    bus_b.enable = 1'b1;
    push_b();
    #3;
    check("pre_reset_index", bus_a.index, 2'd3);
    rst_a = 1'b1;
    #1;
    check("async_reset_rc", bus_a.ring_counter, 4'b0000);
    check("async_reset_index", bus_a.index, 2'd0);
    check("async_reset_fd", bus_a.frame_done, 1'b0);
    rst_a   = 1'b0;
    m_cnt   = 0;
    m_slot  = 0;
    m_valid = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    #2;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("a_ring_counter", bus_a.ring_counter, e.rc);
      check("a_index", bus_a.index, e.idx);
      check("a_frame_done", bus_a.frame_done, e.fd);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("b_ring_counter", bus_b.ring_counter, e.rc);
      check("b_index", bus_b.index, e.idx);
      check("b_frame_done", bus_b.frame_done, e.fd);
      b_samples++;
      if (bus_b.frame_done) b_frames++;
    end
    check("a_rc_onehot_or_zero", (bus_a.ring_counter == 4'b0000) || $onehot(bus_a.ring_counter), 1'b1);
    check("b_rc_onehot_or_zero", (bus_b.ring_counter == 4'b0000) || $onehot(bus_b.ring_counter), 1'b1);
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.enable = 1'b1;
    bus_b.enable = 1'b1;
    #1;
    check("reset_a_rc", bus_a.ring_counter, 4'b0000);
    check("reset_a_index", bus_a.index, 2'd0);
    check("reset_a_fd", bus_a.frame_done, 1'b0);
    check("reset_b_rc_guard0", bus_b.ring_counter, 4'b0001);
    bus_a.enable = 1'b0;
    bus_b.enable = 1'b0;
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Scenario 1: full frame against the literal sequence, then one more edge.
    tab_idx = 0;
    for (int i = 0; i < 17; i++) drive(1'b1);

    // Pause in slot 2, mid-slot, then resume.
    for (int i = 0; i < 32 && !(m_slot == 2 && m_cnt == 2); i++) drive(1'b1);
    check("pause_reached", (m_slot == 2 && m_cnt == 2), 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1);

    // Async reset while slot 3 is selected, then the scenario-1 sequence again.
    for (int i = 0; i < 32 && !(m_slot == 3 && m_cnt == 1); i++) drive(1'b1);
    check("reset_point_reached", (m_slot == 3 && m_cnt == 1), 1'b1);
    pulse_reset_a();
    tab_idx = 0;
    for (int i = 0; i < 16; i++) drive(1'b1);

    // Corrupt the ring, let it recover, then expect scenario-1 frames again.
    drive_corrupt();
    for (int i = 0; i < 16 && !(m_valid && m_cnt == 0 && m_slot == 0); i++) drive(1'b1);
    check("recovery_reached", (m_valid && m_cnt == 0 && m_slot == 0), 1'b1);
    tab_idx = 0;
    for (int i = 0; i < 16; i++) drive(1'b1);
    tab_idx = 16;
    for (int i = 0; i < 16; i++) drive(1'b1);

    @(negedge clk);
    bus_a.enable = 1'b0;
    #5;
    check("queue_a_drained", q_a.size(), 0);
    check("queue_b_drained", q_b.size(), 0);
    check("b_frame_count", b_frames, b_samples / 8);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
